sequence_tracker_logic: RTL
===========================

// Module: sequence_tracker_logic
// PURPOSE
//  Stream sink for the generator_logic valid/ready stream. Paces up_ready with a
//  configurable duty cycle, checks each accepted word against an incrementing
//  sequence modulo 2^DW, and reports transfer/error statistics to the testbench.
//  Sits at the downstream end of the generator -> tracker pair.
// PARAMETERS
//  DW           16  data width; must match the generator
//  READY_PERIOD 3   ready asserted 1 of every READY_PERIOD cycles (>=1; 1 = always ready)
//  CNT_W        32  width of the transfer and error counters
//  START_VAL    1   first expected word after reset/clear (the generator's first word is 1)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  up_valid      in   1      producer valid
//  up_data       in   DW     producer data
//  up_ready      out  1      sink ready
//  enable        in   1      allow ready pacing; 0 = up_ready held low
//  clear         in   1      synchronous clear of statistics and sequence state
//  xfer_cnt      out  CNT_W  accepted transfers, saturating
//  err_cnt       out  CNT_W  sequence mismatches, saturating
//  err_flag      out  1      sticky: at least one mismatch since reset/clear
//  err_expected  out  DW     expected value at the FIRST mismatch
//  err_actual    out  DW     received value at the FIRST mismatch
//  last_data     out  DW     most recently accepted word
// BEHAVIOUR
//  - Reset (rst_n=0, async): up_ready=0, all counters/flags/captures=0, expected=START_VAL,
//    FSM=S_IDLE, pace=0. Outputs take reset values immediately, without waiting for clk.
//  - Transfer = up_valid && up_ready at a rising clk edge.
//  - up_ready = enable && !clear && (state==S_RDY). No combinational path from up_valid.
//  - FSM:
//    S_IDLE: enable=1 -> S_WAIT with pace=0; if READY_PERIOD==1, go to S_RDY instead.
//    S_WAIT: pace increments each cycle; pace==READY_PERIOD-2 -> S_RDY.
//    S_RDY:  ready held until a transfer occurs. On a transfer: -> S_WAIT, pace=0
//            (stays in S_RDY when READY_PERIOD==1).
//    From any state: enable=0 -> S_IDLE. up_ready drops in the same cycle (gated comb).
//  - Spacing: with up_valid always 1, transfers occur every READY_PERIOD cycles.
//    The first ready is READY_PERIOD cycles after enable rises.
//  - Check on each transfer:
//    - Match (up_data==expected): expected <= up_data+1, wrapping modulo 2^DW.
//    - Mismatch: err_cnt++, err_flag<=1. err_expected/err_actual are loaded only when
//      err_flag was 0. Then resync expected <= up_data+1, so a single dropped word
//      counts as exactly one error.
//    - Every transfer: xfer_cnt++, last_data<=up_data.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - clear=1: same effect as reset, but synchronous. up_ready is forced to 0 for that
//    cycle, so a clear never coincides with a transfer. The FSM returns to S_IDLE.
//  - up_valid=1 while up_ready=0: no state change. Data is not sampled.
//  - Reset mid-handshake: the transfer is lost. The generator is reset together with
//    the tracker, so both restart in step at START_VAL.
// TESTING
//  1. READY_PERIOD=3, enable=1, generator continuous, 10 transfers -> handshakes 3 cycles
//     apart; xfer_cnt=10, err_cnt=0, last_data=10.
//  2. Drive data 1,2,4,5 -> err_cnt=1, err_flag=1, err_expected=3, err_actual=4;
//     word 5 is accepted with no new error.
//  3. DW=4, 20 transfers 1..15,0,1..4 -> err_cnt=0, last_data=4 (wrap checked).
//  4. Hold up_valid=0 for 5 cycles while in S_RDY -> up_ready stays 1, xfer_cnt unchanged;
//     raise up_valid -> exactly one transfer, then up_ready=0 for READY_PERIOD-1 cycles.
//  5. clear after 6 transfers -> up_ready=0 that cycle; counters=0, err_flag=0; next word 1
//     passes. Pull rst_n low mid-run -> outputs reset with no clk edge.
//  6. CNT_W=4, 20 transfers -> xfer_cnt=15 (saturated); enable=0 -> up_ready low same cycle.

Source files
------------

// File: rtl/sequence_tracker_logic.sv
// Stream sink that paces up_ready, checks an incrementing sequence and keeps transfer/error statistics.
// Latency: statistics update on the clock edge of each accepted word; up_ready is a registered-state decode gated by enable/clear.
// Backpressure: up_ready asserts once every READY_PERIOD cycles and holds until a transfer; enable=0 or clear=1 drop it immediately.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   up_valid/up_data      producer stream in;  up_ready  sink ready out
//   enable                allow ready pacing (0 holds up_ready low)
//   clear                 synchronous clear of statistics and sequence state
//   xfer_cnt, err_cnt     saturating transfer and mismatch counters
//   err_flag              sticky mismatch indicator
//   err_expected/actual   expected/received words captured at the first mismatch
//   last_data             most recently accepted word
module sequence_tracker_logic #(
    parameter int DW           = 16,
    parameter int READY_PERIOD = 3,
    parameter int CNT_W        = 32,
    parameter int START_VAL    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [DW-1:0]    up_data,
    output logic             up_ready,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [DW-1:0]    err_expected,
    output logic [DW-1:0]    err_actual,
    output logic [DW-1:0]    last_data
);

    // pace only ever reaches READY_PERIOD-2, so clog2(READY_PERIOD) bits suffice
    localparam int PW = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PW-1:0] PACE_LAST = PW'((READY_PERIOD >= 2) ? READY_PERIOD - 2 : 0);
    localparam logic [DW-1:0] START_WORD = DW'(START_VAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RDY
    } state_t;

    state_t        state, next_state;
    logic [PW-1:0] pace, next_pace;
    logic [DW-1:0] expected;
    logic          xfer;

    // Ready is a decode of registered state; up_valid never feeds it.
    assign up_ready = enable && !clear && (state == S_RDY);
    assign xfer     = up_valid && up_ready;

    always_comb begin
        next_state = state;
        next_pace  = pace;
        if (!enable) begin
            next_state = S_IDLE;
            next_pace  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    next_pace  = '0;
                    next_state = (READY_PERIOD == 1) ? S_RDY : S_WAIT;
                end
                S_WAIT: begin
                    if (pace == PACE_LAST) begin
                        next_state = S_RDY;
                        next_pace  = '0;
                    end else begin
                        next_pace = pace + 1'b1;
                    end
                end
                S_RDY: begin
                    // with a period of 1 the sink simply stays ready
                    if (xfer && (READY_PERIOD != 1)) begin
                        next_state = S_WAIT;
                        next_pace  = '0;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                    next_pace  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pace  <= '0;
        end else if (clear) begin
            state <= S_IDLE;
            pace  <= '0;
        end else begin
            state <= next_state;
            pace  <= next_pace;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected     <= START_WORD;
            xfer_cnt     <= '0;
            err_cnt      <= '0;
            err_flag     <= 1'b0;
            err_expected <= '0;
            err_actual   <= '0;
            last_data    <= '0;
        end else if (clear) begin
            expected     <= START_WORD;
            xfer_cnt     <= '0;
            err_cnt      <= '0;
            err_flag     <= 1'b0;
            err_expected <= '0;
            err_actual   <= '0;
            last_data    <= '0;
        end else if (xfer) begin
            // Resync on every word, so a single dropped word costs exactly one error.
            expected  <= up_data + 1'b1;
            last_data <= up_data;
            if (xfer_cnt != '1) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (up_data != expected) begin
                err_flag <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                // capture only the first mismatch since reset/clear
                if (!err_flag) begin
                    err_expected <= expected;
                    err_actual   <= up_data;
                end
            end
        end
    end

endmodule
